// File: rtl/ysyx_220066_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220066_mem_arb_if
// Brief    : Bundle of fetch, load/store and shared-memory signals for the
//            fetch / load-store memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_220066_mem_arb_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_wr;
    logic [2:0]  ls_op;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic        ls_done;
    logic [63:0] ls_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        error;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_op, ls_addr, ls_wdata,
               mem_ack, mem_rdata,
        output if_rvalid, if_rdata, ls_done, ls_rdata,
               mem_req, mem_wr, mem_op, mem_addr, mem_wdata, error
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_op, ls_addr, ls_wdata,
               mem_ack, mem_rdata,
        input  if_rvalid, if_rdata, ls_done, ls_rdata,
               mem_req, mem_wr, mem_op, mem_addr, mem_wdata, error
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_220066_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220066_mem_arb
// Brief    : Two-requester (fetch, load/store) arbiter onto one memory port,
//            alternating on conflict, with a sticky wait-timeout error state.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220066_mem_arb (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_220066_mem_arb_if.slave        bus
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IF_BUSY = 2'd1;
    localparam logic [1:0] c_ST_LS_BUSY = 2'd2;
    localparam logic [1:0] c_ST_ERR     = 2'd3;

    localparam logic       c_GRANT_IF   = 1'b0;
    localparam logic       c_GRANT_LS   = 1'b1;
    localparam logic [2:0] c_OP_FETCH   = 3'b110;
    // Counter value seen in the 255th consecutive busy cycle without an ack
    localparam logic [7:0] c_WAIT_LAST  = 8'd254;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last_grant;
    logic [7:0]  r_wait_cnt;
    logic        r_wr;
    logic [2:0]  r_op;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic        w_grant_if;
    logic        w_grant_ls;
    logic        w_busy;

    logic        w_if_rvalid;
    logic [31:0] w_if_rdata;
    logic        w_ls_done;
    logic [63:0] w_ls_rdata;
    logic        w_mem_req;
    logic        w_mem_wr;
    logic [2:0]  w_mem_op;
    logic [63:0] w_mem_addr;
    logic [63:0] w_mem_wdata;
    logic        w_error;

    assign w_busy = (r_state == c_ST_IF_BUSY) || (r_state == c_ST_LS_BUSY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_ls   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.if_req && bus.ls_req) begin
                    w_grant_ls = (r_last_grant == c_GRANT_IF);
                    w_grant_if = (r_last_grant == c_GRANT_LS);
                end else begin
                    w_grant_if = bus.if_req;
                    w_grant_ls = bus.ls_req;
                end
                if (w_grant_if) begin
                    w_next_state = c_ST_IF_BUSY;
                end else if (w_grant_ls) begin
                    w_next_state = c_ST_LS_BUSY;
                end
            end
            c_ST_IF_BUSY, c_ST_LS_BUSY: begin
                if (bus.mem_ack) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_next_state = c_ST_ERR;
                end
            end
            default: w_next_state = c_ST_ERR;
        endcase
    end

    // Request is captured at grant so requesters may drop or change it mid-flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= c_GRANT_IF;
            r_wait_cnt   <= 8'd0;
            r_wr         <= 1'b0;
            r_op         <= 3'd0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
        end else if (w_grant_if) begin
            r_last_grant <= c_GRANT_IF;
            r_wait_cnt   <= 8'd0;
            r_wr         <= 1'b0;
            r_op         <= c_OP_FETCH;
            r_addr       <= bus.if_addr;
            r_wdata      <= 64'd0;
        end else if (w_grant_ls) begin
            r_last_grant <= c_GRANT_LS;
            r_wait_cnt   <= 8'd0;
            r_wr         <= bus.ls_wr;
            r_op         <= bus.ls_op;
            r_addr       <= bus.ls_addr;
            r_wdata      <= bus.ls_wdata;
        end else if (w_busy && !bus.mem_ack) begin
            r_wait_cnt   <= r_wait_cnt + 8'd1;
        end
    end

    // Every output is forced low while reset is held
    always_comb begin
        w_if_rvalid = 1'b0;
        w_if_rdata  = 32'd0;
        w_ls_done   = 1'b0;
        w_ls_rdata  = 64'd0;
        w_mem_req   = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_op    = 3'd0;
        w_mem_addr  = 64'd0;
        w_mem_wdata = 64'd0;
        w_error     = 1'b0;
        if (rst) begin
            if (w_busy) begin
                w_mem_req   = 1'b1;
                w_mem_wr    = r_wr;
                w_mem_op    = r_op;
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
            end
            if ((r_state == c_ST_IF_BUSY) && bus.mem_ack) begin
                w_if_rvalid = 1'b1;
                w_if_rdata  = r_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end
            if ((r_state == c_ST_LS_BUSY) && bus.mem_ack) begin
                w_ls_done  = 1'b1;
                w_ls_rdata = bus.mem_rdata;
            end
            w_error = (r_state == c_ST_ERR);
        end
    end

    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = w_if_rdata;
    assign bus.ls_done   = w_ls_done;
    assign bus.ls_rdata  = w_ls_rdata;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_op    = w_mem_op;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.error     = w_error;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220066_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_220066_mem_arb
// Brief    : Self-checking bench for the fetch / load-store memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_220066_mem_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ysyx_220066_mem_arb_if bus();

    ysyx_220066_mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [231:0] all_outs();
        return {bus.if_rvalid, bus.if_rdata, bus.ls_done, bus.ls_rdata,
                bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr,
                bus.mem_wdata, bus.error};
    endfunction

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 64'd0;
        bus.ls_req    = 1'b0;
        bus.ls_wr     = 1'b0;
        bus.ls_op     = 3'd0;
        bus.ls_addr   = 64'd0;
        bus.ls_wdata  = 64'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req    = 1'b1;
        bus.ls_req    = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (all_outs() !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", all_outs());
            end
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_release_idle got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_fetch_only();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h0000_0000_8000_0004;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0}) begin
            failures++;
            $display("FAIL fetch_mem_fields got=%h exp=%h",
                     {bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata},
                     {1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0});
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.if_rvalid, bus.if_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL fetch_wait got=%h exp=%h",
                     {bus.mem_req, bus.if_rvalid, bus.if_rdata}, {1'b1, 1'b0, 32'd0});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h0010_0093_0000_0013;
        #1;
        checks++;
        if ({bus.if_rvalid, bus.if_rdata, bus.ls_done} !== {1'b1, 32'h0010_0093, 1'b0}) begin
            failures++;
            $display("FAIL fetch_rdata got=%h exp=%h",
                     {bus.if_rvalid, bus.if_rdata, bus.ls_done}, {1'b1, 32'h0010_0093, 1'b0});
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        #1;
        checks++;
        if ({bus.if_rvalid, bus.if_rdata, bus.mem_req} !== 34'd0) begin
            failures++;
            $display("FAIL fetch_pulse_end got=%h exp=0",
                     {bus.if_rvalid, bus.if_rdata, bus.mem_req});
        end
    endtask

    task automatic test_conflict();
        logic [63:0] rdata;
        do_reset();
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h0000_0000_8000_0000;
        bus.ls_req   = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_op    = 3'b011;
        bus.ls_addr  = 64'h0000_0000_8000_1000;
        bus.ls_wdata = 64'h0000_0000_0000_DEAD;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b1, 3'b011, 64'h8000_1000, 64'hDEAD}) begin
            failures++;
            $display("FAIL conflict_ls_first got=%h exp=%h",
                     {bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata},
                     {1'b1, 1'b1, 3'b011, 64'h8000_1000, 64'hDEAD});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        checks++;
        if ({bus.ls_done, bus.if_rvalid} !== 2'b10) begin
            failures++;
            $display("FAIL conflict_ls_done got=%b exp=10", {bus.ls_done, bus.if_rvalid});
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.ls_req  = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL conflict_idle_gap got=%b exp=0", bus.mem_req);
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr} !==
            {1'b1, 1'b0, 3'b110, 64'h8000_0000}) begin
            failures++;
            $display("FAIL conflict_if_second got=%h exp=%h",
                     {bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr},
                     {1'b1, 1'b0, 3'b110, 64'h8000_0000});
        end
        rdata = {$urandom, $urandom};
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        #1;
        checks++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, rdata[31:0]}) begin
            failures++;
            $display("FAIL conflict_if_rdata got=%h exp=%h",
                     {bus.if_rvalid, bus.if_rdata}, {1'b1, rdata[31:0]});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic exp_ls;
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h0000_0000_8000_0000;
        bus.ls_req  = 1'b1;
        bus.ls_wr   = 1'b0;
        bus.ls_op   = 3'b011;
        bus.ls_addr = 64'h0000_0000_8000_2000;
        for (int t = 0; t < 4; t++) begin
            exp_ls = (t % 2 == 0);
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.mem_addr} !==
                {1'b1, exp_ls ? 64'h8000_2000 : 64'h8000_0000}) begin
                failures++;
                $display("FAIL fair_grant_%0d got=%h exp=%h", t, {bus.mem_req, bus.mem_addr},
                         {1'b1, exp_ls ? 64'h8000_2000 : 64'h8000_0000});
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = {$urandom, $urandom};
            #1;
            checks++;
            if ({bus.if_rvalid, bus.ls_done} !== (exp_ls ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL fair_pulse_%0d got=%b exp=%b", t, {bus.if_rvalid, bus.ls_done},
                         exp_ls ? 2'b01 : 2'b10);
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            checks++;
            if (bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL fair_idle_gap_%0d got=%b exp=0", t, bus.mem_req);
            end
        end
        idle_inputs();
    endtask

    // Transaction-level model: conflicts go to the requester not served last
    task automatic test_random(input int rounds);
        logic        last_ls, pend_if, pend_ls, win_ls;
        logic [63:0] a_if, a_ls, wd_ls, rdata;
        logic [2:0]  op_ls;
        logic        wr_ls;
        logic [132:0] exp_mem;
        logic [97:0]  exp_rsp;
        int          delay;
        do_reset();
        last_ls = 1'b0;
        for (int r = 0; r < rounds; r++) begin
            pend_if = 1'($urandom_range(0, 1));
            pend_ls = 1'($urandom_range(0, 1));
            if (!pend_if && !pend_ls) pend_if = 1'b1;
            a_if  = {$urandom, $urandom};
            a_ls  = {$urandom, $urandom};
            wd_ls = {$urandom, $urandom};
            op_ls = 3'($urandom_range(0, 7));
            wr_ls = 1'($urandom_range(0, 1));
            bus.if_req   = pend_if;
            bus.if_addr  = a_if;
            bus.ls_req   = pend_ls;
            bus.ls_wr    = wr_ls;
            bus.ls_op    = op_ls;
            bus.ls_addr  = a_ls;
            bus.ls_wdata = wd_ls;
            while (pend_if || pend_ls) begin
                win_ls  = (pend_if && pend_ls) ? !last_ls : pend_ls;
                exp_mem = win_ls ? {1'b1, wr_ls, op_ls, a_ls, wd_ls}
                                 : {1'b1, 1'b0, 3'b110, a_if, 64'd0};
                @(negedge clk);
                checks++;
                if ({bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== exp_mem) begin
                    failures++;
                    $display("FAIL rand_mem_fields r=%0d got=%h exp=%h", r,
                             {bus.mem_req, bus.mem_wr, bus.mem_op, bus.mem_addr, bus.mem_wdata}, exp_mem);
                end
                delay = $urandom_range(0, 4);
                for (int d = 0; d < delay; d++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if (win_ls) begin
                            bus.ls_req  = 1'b0;
                            bus.ls_addr = {$urandom, $urandom};
                        end else begin
                            bus.if_req  = 1'b0;
                            bus.if_addr = {$urandom, $urandom};
                        end
                    end
                    bus.mem_rdata = {$urandom, $urandom};
                    @(negedge clk);
                    checks++;
                    if ({bus.mem_req, bus.mem_addr, bus.if_rvalid, bus.ls_done, bus.if_rdata, bus.ls_rdata} !==
                        {1'b1, exp_mem[127:64], 2'b00, 96'd0}) begin
                        failures++;
                        $display("FAIL rand_wait r=%0d got=%h exp=%h", r,
                                 {bus.mem_req, bus.mem_addr, bus.if_rvalid, bus.ls_done, bus.if_rdata, bus.ls_rdata},
                                 {1'b1, exp_mem[127:64], 2'b00, 96'd0});
                    end
                end
                rdata = {$urandom, $urandom};
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                exp_rsp = win_ls ? {1'b0, 32'd0, 1'b1, rdata}
                                 : {1'b1, a_if[2] ? rdata[63:32] : rdata[31:0], 1'b0, 64'd0};
                #1;
                checks++;
                if ({bus.if_rvalid, bus.if_rdata, bus.ls_done, bus.ls_rdata} !== exp_rsp) begin
                    failures++;
                    $display("FAIL rand_response r=%0d got=%h exp=%h", r,
                             {bus.if_rvalid, bus.if_rdata, bus.ls_done, bus.ls_rdata}, exp_rsp);
                end
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = {$urandom, $urandom};
                if (win_ls) begin
                    pend_ls    = 1'b0;
                    bus.ls_req = 1'b0;
                end else begin
                    pend_if    = 1'b0;
                    bus.if_req = 1'b0;
                end
                last_ls = win_ls;
                #1;
                checks++;
                if ({bus.mem_req, bus.if_rvalid, bus.ls_done, bus.if_rdata, bus.ls_rdata} !== 99'd0) begin
                    failures++;
                    $display("FAIL rand_idle r=%0d got=%h exp=0", r,
                             {bus.mem_req, bus.if_rvalid, bus.ls_done, bus.if_rdata, bus.ls_rdata});
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int busy;
        do_reset();
        bus.ls_req  = 1'b1;
        bus.ls_wr   = 1'b0;
        bus.ls_op   = 3'b011;
        bus.ls_addr = 64'h0000_0000_8000_3000;
        busy = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1) break;
            busy++;
        end
        checks++;
        if (busy != 255) begin
            failures++;
            $display("FAIL timeout_busy_cycles got=%0d exp=255", busy);
        end
        checks++;
        if ({bus.error, bus.mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_error_flag got=%b exp=10", {bus.error, bus.mem_req});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        #1;
        checks++;
        if ({bus.if_rvalid, bus.ls_done, bus.ls_rdata} !== 66'd0) begin
            failures++;
            $display("FAIL timeout_late_ack got=%h exp=0", {bus.if_rvalid, bus.ls_done, bus.ls_rdata});
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.ls_req  = 1'b0;
        bus.if_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.error, bus.mem_req, bus.if_rvalid} !== 3'b100) begin
                failures++;
                $display("FAIL timeout_no_grant got=%b exp=100", {bus.error, bus.mem_req, bus.if_rvalid});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.ls_req  = 1'b1;
        bus.ls_wr   = 1'b0;
        bus.ls_op   = 3'b011;
        bus.ls_addr = 64'h0000_0000_8000_4000;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL midop_busy got=%b exp=1", bus.mem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL midop_outputs_in_reset got=%h exp=0", all_outs());
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.ls_req    = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        #1;
        checks++;
        if ({bus.ls_done, bus.if_rvalid, bus.mem_req, bus.error} !== 4'd0) begin
            failures++;
            $display("FAIL midop_late_ack got=%b exp=0000",
                     {bus.ls_done, bus.if_rvalid, bus.mem_req, bus.error});
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h0000_0000_8000_0010;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_op, bus.mem_addr, bus.error} !==
            {1'b1, 3'b110, 64'h8000_0010, 1'b0}) begin
            failures++;
            $display("FAIL midop_idle_after got=%h exp=%h",
                     {bus.mem_req, bus.mem_op, bus.mem_addr, bus.error},
                     {1'b1, 3'b110, 64'h8000_0010, 1'b0});
        end
        bus.mem_ack = 1'b1;
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL midop_fetch_done got=%b exp=1", bus.if_rvalid);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_conflict();
        test_fairness();
        test_random(40);
        test_timeout();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_220066_mem_arb.md
YSYX_220066_MEM_ARB -- requirements
Module: ysyx_220066_mem_arb

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset rst, synchronous, active-low.
REQ-003 if_req  input  1  fetch request, held until if_rvalid.
REQ-004 if_addr  input  64  fetch address, stable while if_req=1.
REQ-005 if_rvalid  output  1  one-cycle pulse: fetch data valid.
REQ-006 if_rdata  output  32  instruction word: mem_rdata[31:0] if if_addr[2]=0, else mem_rdata[63:32].
REQ-007 ls_req  input  1  load/store request, held until ls_done.
REQ-008 ls_wr  input  1  1=store, 0=load.
REQ-009 ls_op  input  3  MemOp size/sign code, passed to memory unchanged.
REQ-010 ls_addr  input  64  data address.
REQ-011 ls_wdata  input  64  store data.
REQ-012 ls_done  output  1  one-cycle pulse: load data valid or store complete.
REQ-013 ls_rdata  output  64  load data, equal to mem_rdata in the ls_done cycle.
REQ-014 mem_req  output  1  memory request to the single shared port.
REQ-015 mem_wr  output  1  write strobe; 1 only for granted stores.
REQ-016 mem_op  output  3  size code; fetch uses 3'b110 (32-bit unsigned).
REQ-017 mem_addr  output  64  memory address.
REQ-018 mem_wdata  output  64  write data; 0 during fetch.
REQ-019 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-020 mem_rdata  input  64  read data, valid when mem_ack=1.
REQ-021 error  output  1  sticky timeout flag.

Function
REQ-022 FSM states SHALL be IDLE, IF_BUSY, LS_BUSY, ERR.
REQ-023 IDLE: only if_req -> IF_BUSY; only ls_req -> LS_BUSY; neither -> stay.
REQ-024 IDLE, both pending: grant opposite of last_grant (1-bit reg, 0=IF, 1=LS); last_grant resets to IF so first conflict goes to LS.
REQ-025 last_grant SHALL update on every transition out of IDLE.
REQ-026 In IF_BUSY/LS_BUSY, mem_req=1 and mem_addr/mem_op/mem_wr/mem_wdata driven from a request latched on grant; in IDLE and ERR all mem_* outputs are 0.
REQ-027 Grant-to-mem_req latency: mem_req asserted the cycle after grant decision (registered state).
REQ-028 mem_ack in IF_BUSY: if_rvalid=1 combinationally that cycle, state -> IDLE next edge.
REQ-029 mem_ack in LS_BUSY: ls_done=1 combinationally that cycle, state -> IDLE next edge.
REQ-030 mem_ack in IDLE or ERR SHALL be ignored; no output pulses.
REQ-031 No back-to-back grant in the ack cycle; minimum one IDLE cycle between transactions.
REQ-032 8-bit wait counter cleared on grant, increments each busy cycle without mem_ack; busy reaching 255 without ack -> ERR.
REQ-033 ERR: error=1, no grants, if_rvalid=ls_done=0; exit only via reset.
REQ-034 Request deassertion while busy SHALL not abort the transaction; response pulse still issued.
REQ-035 if_rdata/ls_rdata SHALL be 0 outside their valid pulses.

Reset
REQ-036 rst=0 at clock edge: state=IDLE, last_grant=IF, counter=0, error=0, latched request cleared.
REQ-037 Reset mid-transaction abandons it; no if_rvalid/ls_done, mem_req=0 from next cycle; late mem_ack ignored.
REQ-038 All outputs SHALL be 0 while rst=0.

Verification
REQ-039 Fetch only: if_req, if_addr=0x80000004; mem_ack 2 cycles later, mem_rdata=0x00100093_00000013 -> mem_op=110, mem_wr=0, if_rvalid 1 cycle, if_rdata=0x00100093.
REQ-040 Conflict: if_req and ls_req (store 0x80001000, data 0xDEAD) same cycle after reset -> LS first (mem_wr=1, mem_wdata=0xDEAD), ls_done; then IF granted after one IDLE cycle.
REQ-041 Fairness: both requests held across 4 transactions -> grants alternate LS, IF, LS, IF.
REQ-042 Timeout: grant load, never ack -> error=1 after 255 busy cycles, mem_req=0, later mem_ack ignored, new requests not granted.
REQ-043 Reset mid-op: rst=0 during LS_BUSY, then mem_ack after release -> no ls_done, state IDLE, error=0.
